// File: rtl/cdc_handshake_receiver.sv
// Receive side of a four-phase req/ack clock-domain crossing with a one-entry valid/ready buffer.
// Optional incrementing-sequence checker compiled in with `define CDC_RX_SEQ_CHECK_EN.
module cdc_handshake_receiver #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic             ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             seq_err,
  output logic [7:0]       err_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   req_s;
  logic [0:0]             state;
  logic                   capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p <= '0;
    else        sync_p <= {sync_p[SYNC_STAGES-2:0], en};
  end

  assign req_s = sync_p[SYNC_STAGES-1];

  // data is only looked at while req_s is high, when the sender holds it stable
  assign capture = (state == ST_IDLE) && req_s && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ack   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (capture) begin
          state <= ST_ACK;
          ack   <= 1'b1;
        end
        ST_ACK: if (!req_s) begin
          state <= ST_IDLE;
          ack   <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CDC_RX_SEQ_CHECK_EN
  logic [WIDTH-1:0] expected;
  logic             have_exp;
  logic             mismatch;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // the very first word after reset only seeds the expectation
  assign mismatch = have_exp && (data != expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected <= '0;
      have_exp <= 1'b0;
      seq_err  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      seq_err <= 1'b0;
      if (capture) begin
        expected <= data + WIDTH'(1);
        have_exp <= 1'b1;
        if (mismatch) begin
          seq_err <= 1'b1;
          err_cnt <= sat_inc(err_cnt);
        end
      end
    end
  end
`else
  assign seq_err = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: doc/cdc_handshake_receiver.md
# cdc_handshake_receiver

Receiving end of the four-phase request/acknowledge clock-domain crossing. Samples the sender's asynchronous `en`/`data` pair in its own clock domain and captures the word into a one-entry output buffer with a valid/ready interface. Drives `ack` back to the sender and optionally checks that received words form an incrementing sequence. Sits directly downstream of the sender stage and upstream of the receive-domain consumer.

## Interface
- `WIDTH`, 4, data width; matches the sender's `data`.
- `SYNC_STAGES`, 2, flops in the `en` synchronizer; legal range 2..4.
- `clk`  in  1  receive-domain clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  request from the sender domain; asynchronous; held high until `ack` is seen.
- `data`  in  WIDTH  sender data; asynchronous; stable whenever `en` is high.
- `ack`  out  1  acknowledge to the sender; registered.
- `out_data`  out  WIDTH  captured word.
- `out_valid`  out  1  buffer holds a word.
- `out_ready`  in  1  consumer accepts the word.
- `seq_err`  out  1  one-cycle pulse on a sequence violation.
- `err_cnt`  out  8  saturating count of sequence violations.

## Operation
- `en` passes through a `SYNC_STAGES`-flop synchronizer; `req_s` is the last stage. `data` is never synchronized; it is sampled only when `req_s` is high, when the protocol guarantees it is stable.
- FSM, two states:
  - IDLE: `ack`=0. Capture when `req_s`=1 and the buffer is free (`!out_valid || out_ready`). On capture: `out_data`<=`data`, `out_valid`<=1, `ack`<=1, go to ACK. If `req_s`=1 and the buffer is not free, stay in IDLE (stall) with `ack` held at 0.
  - ACK: `ack`=1. Wait for `req_s`=0, then `ack`<=0 and go to IDLE.
- A new request is captured only after returning to IDLE, so each high phase of `en` yields exactly one word.
- Buffer: `out_valid` clears on `out_valid && out_ready` unless a capture happens in the same cycle. Capture plus pop in the same cycle keeps `out_valid`=1 and replaces `out_data`.
- Reset values: state IDLE, synchronizer 0, `ack`=0, `out_valid`=0, `out_data`=0, `seq_err`=0, `err_cnt`=0. Reset asserted mid-handshake drops `ack` asynchronously and discards the buffered word. The sender is expected to be reset together with this block.

## Timing
- `en` first sampled high at edge k: `req_s` goes high at edge k+SYNC_STAGES-1, and `ack`/`out_valid` go high at edge k+SYNC_STAGES when the buffer is free.
- `en` first sampled low at edge m: `ack` goes low at edge m+SYNC_STAGES.
- Minimum round trip, from `en` rising to the receiver being ready in IDLE again, is 2·SYNC_STAGES+1 receive clocks, plus the sender-side synchronization delay.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `CDC_RX_SEQ_CHECK_EN` defined:
  - A WIDTH-bit `expected` register is compiled in.
  - The first capture after reset only loads `expected` <= `data`+1.
  - Each later capture compares `data` with `expected`; on mismatch, `seq_err` pulses for one cycle on the capture edge and `err_cnt` increments, saturating at 255.
  - `expected` is always reloaded with `data`+1, modulo 2^WIDTH, so the wrap from 15 to 0 is legal at WIDTH=4.
- Not defined: no checker logic; `seq_err` and `err_cnt` are tied to 0.

## Test plan
- Single transfer: `en` rises with `data`=1 and `out_ready`=1 -> `ack` and `out_valid` rise 2 edges later with `out_data`=1. Drop `en` -> `ack` falls 2 edges later.
- Back-pressure: `out_ready`=0 holding word 3, sender raises `en` with 4 -> `ack` stays 0. Pulse `out_ready` -> word 3 pops, 4 is captured, and `ack` rises in the same edge.
- Sequence wrap (macro on): send 1..15, 0, 1 -> `seq_err` never pulses and `err_cnt`=0.
- Gap (macro on): send 5, 6, 8 -> one `seq_err` pulse on capture of 8 and `err_cnt`=1; then send 9 -> no error.
- Reset mid-handshake: drop `rst_n` while in ACK -> `ack`, `out_valid` and `err_cnt` go to 0 immediately. After release, the next request is captured normally.
- Stress: random `out_ready` and random sender gaps, 1000 words -> every word is delivered exactly once and in order, and `err_cnt`=0.
